// File: rtl/sync_delay_pipe.sv
// sync_delay_pipe: DEPTH-stage valid/ready register pipeline. Each stage holds
// one beat; a stage loads whenever it is empty or its beat moves on, so
// bubbles collapse toward the output and full throughput is kept when
// out_ready is high. Optional bit reversal is pure wiring on the input.
//
// Ports
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   flush     : synchronous discard of all held beats (blocks input that cycle)
//   in_valid  : upstream beat present
//   in_ready  : beat accepted this cycle
//   in_data   : upstream payload, WIDTH bits
//   out_valid : last stage holds a beat
//   out_ready : downstream accepts the beat
//   out_data  : last-stage payload, WIDTH bits (holds last value when empty)
//   count     : occupied stages, 0..DEPTH

// One pipeline stage: valid bit plus data register.
module sdp_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             take,      // stage may load this cycle
   input  logic             src_vld,
   input  logic [WIDTH-1:0] src_dat,
   output logic             vld,
   output logic [WIDTH-1:0] dat
);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= 1'b0;
         dat <= '0;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (take) begin
         vld <= src_vld;
         // data only moves with a real beat so an emptied stage keeps its value
         if (src_vld) dat <= src_dat;
      end
   end
endmodule

module sync_delay_pipe #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter bit REVERSE = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [4:0]       count
);
   logic [DEPTH-1:0]            vld_pipe;
   logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
   logic [DEPTH-1:0]            src_vld;
   logic [DEPTH-1:0][WIDTH-1:0] src_dat;
   logic [DEPTH:0]              take;     // take[DEPTH] is the downstream sink
   logic [WIDTH-1:0]            in_data_w;
   logic                        in_hs, out_hs;

   generate
      if (REVERSE) begin : g_rev
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign in_data_w[i] = in_data[WIDTH-1-i];
         end
      end else begin : g_fwd
         assign in_data_w = in_data;
      end
   endgenerate

   // A stage can take a beat if it is empty or the stage after it can take
   // its current beat. Ripples combinationally from out_ready to in_ready.
   always_comb begin
      take        = '0;
      take[DEPTH] = out_ready;
      for (int k = DEPTH-1; k >= 0; k--)
         take[k] = ~vld_pipe[k] | take[k+1];
   end

   assign in_ready  = ~flush & take[0];
   assign in_hs     = in_valid & in_ready;
   assign out_valid = vld_pipe[DEPTH-1];
   assign out_data  = dat_pipe[DEPTH-1];
   assign out_hs    = out_valid & out_ready;

   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_stg
         if (k == 0) begin : g_src_in
            assign src_vld[k] = in_hs;
            assign src_dat[k] = in_data_w;
         end else begin : g_src_prev
            assign src_vld[k] = vld_pipe[k-1];
            assign src_dat[k] = dat_pipe[k-1];
         end
         sdp_stage #(.WIDTH(WIDTH)) u_stg (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .take    (take[k]),
            .src_vld (src_vld[k]),
            .src_dat (src_dat[k]),
            .vld     (vld_pipe[k]),
            .dat     (dat_pipe[k])
         );
      end
   endgenerate

   // Occupancy tracks handshakes; a beat emitted during flush is delivered,
   // the flush still leaves the pipe empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (flush)
         count <= '0;
      else if (in_hs && !out_hs)
         count <= count + 5'd1;
      else if (!in_hs && out_hs)
         count <= count - 5'd1;
   end
endmodule

// File: tb/tb_sync_delay_pipe.sv
// Bench for sync_delay_pipe: main instance (8b, 4 deep), a REVERSE=1 twin fed
// the same stimulus, and a 1-deep instance with its own inputs.
module tb_sync_delay_pipe;
   logic       clk = 1'b0;
   logic       reset_n, flush, in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid;
   logic [7:0] out_data;
   logic [4:0] count;
   logic       rv_in_ready, rv_out_valid;
   logic [7:0] rv_out_data;
   logic [4:0] rv_count;
   logic       d1_in_valid, d1_out_ready, d1_in_ready, d1_out_valid;
   logic [7:0] d1_in_data, d1_out_data;
   logic [4:0] d1_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sync_delay_pipe #(.WIDTH(8), .DEPTH(4), .REVERSE(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .count(count));

   sync_delay_pipe #(.WIDTH(8), .DEPTH(4), .REVERSE(1'b1)) u_rev (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
      .in_ready(rv_in_ready), .in_data(in_data), .out_valid(rv_out_valid),
      .out_ready(out_ready), .out_data(rv_out_data), .count(rv_count));

   sync_delay_pipe #(.WIDTH(8), .DEPTH(1), .REVERSE(1'b0)) u_d1 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(d1_in_valid),
      .in_ready(d1_in_ready), .in_data(d1_in_data), .out_valid(d1_out_valid),
      .out_ready(d1_out_ready), .out_data(d1_out_data), .count(d1_count));

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       fl;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      logic [4:0] e_cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic iv, input logic [7:0] d, input logic ordy,
                      input logic fl, input logic e_ir, input logic e_ov,
                      input logic [7:0] e_od, input logic [4:0] e_cnt);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] brev(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
      in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;

      // stream: accept at edge N, visible after edge N+3
      add(1, 8'h01, 1, 0, 1, 0, 8'h00, 0);
      add(1, 8'h02, 1, 0, 1, 0, 8'h00, 1);
      add(1, 8'h03, 1, 0, 1, 0, 8'h00, 2);
      add(1, 8'h04, 1, 0, 1, 0, 8'h00, 3);
      for (int c = 4; c < 10; c++)
         add(1, 8'(c+1), 1, 0, 1, 1, 8'(c-3), 4);
      // flush while full: input blocked, out_valid unaffected until the edge
      add(1, 8'h0B, 0, 1, 0, 1, 8'h07, 4);
      // backpressure: 6 offered, 4 taken
      for (int i = 1; i <= 4; i++)
         add(1, 8'(i), 0, 0, 1, 0, 8'h07, 5'(i-1));
      add(1, 8'h05, 0, 0, 0, 1, 8'h01, 4);
      add(1, 8'h05, 0, 0, 0, 1, 8'h01, 4);
      add(1, 8'h05, 1, 0, 1, 1, 8'h01, 4);
      add(1, 8'h06, 1, 0, 1, 1, 8'h02, 4);
      add(0, 8'h00, 1, 0, 1, 1, 8'h03, 4);
      add(0, 8'h00, 1, 0, 1, 1, 8'h04, 3);
      add(0, 8'h00, 1, 0, 1, 1, 8'h05, 2);
      add(0, 8'h00, 1, 0, 1, 1, 8'h06, 1);
      add(0, 8'h00, 1, 0, 1, 0, 8'h06, 0);

      // asynchronous reset state, before any clock edge completes
      #2;
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst out_data", out_data, 8'h00);
      chk("rst count", count, 5'd0);
      chk("rst in_ready", in_ready, 1'b1);
      #10;
      reset_n = 1'b1;
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
         chk($sformatf("row%0d count", i), count, tbl[i].e_cnt);
         chk($sformatf("row%0d rev out_data", i), rv_out_data, brev(tbl[i].e_od));
         tick();
      end

      // simultaneous accept/emit while full
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'(8'h10 + i), 0, 0);
         tick();
      end
      for (int j = 0; j < 10; j++) begin
         drive(1, 8'(8'h14 + j), 1, 0);
         chk($sformatf("sim%0d count", j), count, 5'd4);
         chk($sformatf("sim%0d out_valid", j), out_valid, 1'b1);
         chk($sformatf("sim%0d out_data", j), out_data, 8'(8'h10 + j));
         chk($sformatf("sim%0d in_ready", j), in_ready, 1'b1);
         tick();
      end

      // drop to 3 held, then flush for one cycle
      drive(0, 8'h00, 1, 0);
      tick();
      drive(1, 8'h55, 0, 1);
      chk("flush in_ready", in_ready, 1'b0);
      chk("flush out_valid pre", out_valid, 1'b1);
      chk("flush out_data pre", out_data, 8'h1B);
      chk("flush count pre", count, 5'd3);
      tick();
      drive(1, 8'hAA, 1, 0);
      chk("postflush count", count, 5'd0);
      chk("postflush out_valid", out_valid, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h00, 1, 0);
         chk($sformatf("aa_lat%0d out_valid", i), out_valid, 1'b0);
         tick();
      end
      drive(0, 8'h00, 1, 0);
      chk("aa out_valid", out_valid, 1'b1);
      chk("aa out_data", out_data, 8'hAA);
      chk("aa count", count, 5'd1);
      tick();
      chk("aa drained out_valid", out_valid, 1'b0);
      chk("aa drained out_data", out_data, 8'hAA);
      chk("aa drained count", count, 5'd0);

      // bit reversal of an asymmetric pattern
      drive(1, 8'hC5, 1, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h00, 1, 0);
         tick();
      end
      chk("rev C5 out_valid", rv_out_valid, 1'b1);
      chk("rev C5 out_data", rv_out_data, 8'hA3);
      chk("fwd C5 out_data", out_data, 8'hC5);
      tick();

      // async reset mid-cycle with 2 beats held at the output
      drive(1, 8'h31, 0, 0);
      tick();
      drive(1, 8'h32, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h00, 0, 0);
         tick();
      end
      chk("prerst out_valid", out_valid, 1'b1);
      chk("prerst out_data", out_data, 8'h31);
      chk("prerst count", count, 5'd2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst out_valid", out_valid, 1'b0);
      chk("arst count", count, 5'd0);
      chk("arst out_data", out_data, 8'h00);
      chk("arst in_ready", in_ready, 1'b1);
      #1;
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(0, 8'h00, 1, 0);
         chk($sformatf("postrst%0d out_valid", i), out_valid, 1'b0);
         chk($sformatf("postrst%0d count", i), count, 5'd0);
         tick();
      end

      // DEPTH=1 stream: accept at edge N, visible right after edge N
      for (int c = 0; c < 6; c++) begin
         d1_in_valid = 1'b1; d1_in_data = 8'(c+1); d1_out_ready = 1'b1;
         #1;
         chk($sformatf("d1_%0d in_ready", c), d1_in_ready, 1'b1);
         chk($sformatf("d1_%0d out_valid", c), d1_out_valid, c > 0);
         chk($sformatf("d1_%0d count", c), d1_count, (c > 0) ? 5'd1 : 5'd0);
         if (c > 0) chk($sformatf("d1_%0d out_data", c), d1_out_data, 8'(c));
         tick();
      end
      d1_in_data = 8'h07; d1_out_ready = 1'b0;
      #1;
      chk("d1 full in_ready", d1_in_ready, 1'b0);
      chk("d1 full out_data", d1_out_data, 8'h06);
      tick();
      d1_in_valid = 1'b0; d1_out_ready = 1'b1;
      #1;
      chk("d1 held out_data", d1_out_data, 8'h06);
      tick();
      chk("d1 empty out_valid", d1_out_valid, 1'b0);
      chk("d1 empty count", d1_count, 5'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
